mem_port_arbiter: RTL

- Shares one single-ported, synchronous-read instruction/data memory between two requesters: the fetch stage and the LSU.
- A fetch is a two-beat burst that returns an instruction pair (addr, addr+4). A data access is one beat, either a load or a store carrying func3.
- Sits between the IF/LSU stages and the memory array. Sequences every memory access through a small FSM with starvation-bounded priority.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, synchronous-read memory
// between the fetch stage (two-beat instruction-pair burst) and the LSU
// (single-beat load/store). Fetch is promoted over the LSU once it has lost
// STARVE_MAX arbitrations in a row.
// Optional build macro MEM_ARB_PERF_EN adds grant/stall performance counters.

module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_if_req_valid,
  output logic              io_if_req_ready,
  input  logic [ADDR_W-1:0] io_if_req_addr,
  output logic              io_if_resp_valid,
  output logic [DATA_W-1:0] io_if_resp_inst_0,
  output logic [DATA_W-1:0] io_if_resp_inst_1,
  input  logic              io_lsu_req_valid,
  output logic              io_lsu_req_ready,
  input  logic [ADDR_W-1:0] io_lsu_req_addr,
  input  logic              io_lsu_req_writeEn,
  input  logic [DATA_W-1:0] io_lsu_req_writeData,
  input  logic [2:0]        io_lsu_req_func3,
  output logic              io_lsu_resp_valid,
  output logic [DATA_W-1:0] io_lsu_resp_data,
  output logic              io_mem_en,
  output logic [ADDR_W-1:0] io_mem_addr,
  output logic              io_mem_writeEn,
  output logic [DATA_W-1:0] io_mem_writeData,
  output logic [2:0]        io_mem_func3,
  input  logic [DATA_W-1:0] io_mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       io_perf_fetch_grants,
  output logic [31:0]       io_perf_lsu_grants,
  output logic [31:0]       io_perf_fetch_stall
`endif
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, D0, D1} state_t;

  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  state_t            state_reg, state_next;
  logic [3:0]        starve_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [2:0]        mem_func3_reg;
  logic              store_reg;
  logic [DATA_W-1:0] inst_0_reg, inst_1_reg, lsu_data_reg;
  logic              if_resp_reg, lsu_resp_reg;
  logic              if_resp_next, lsu_resp_next;

  logic idle, starve_hit, if_grant, lsu_grant;

  // Arbitration: fetch wins alone or when starved; flush masks fetch only.
  always_comb begin
    idle       = (state_reg == IDLE);
    starve_hit = (starve_cnt_reg == STARVE_LIM);
    if_grant   = idle && !io_flush && io_if_req_valid &&
                 (!io_lsu_req_valid || starve_hit);
    lsu_grant  = idle && io_lsu_req_valid && !if_grant;
  end

  // Next-state and response-pulse decode; flush aborts only fetch beats.
  always_comb begin
    state_next    = state_reg;
    if_resp_next  = 1'b0;
    lsu_resp_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_grant)       state_next = F0;
        else if (lsu_grant) state_next = D0;
      end
      F0: state_next = io_flush ? IDLE : F1;
      F1: state_next = io_flush ? IDLE : F2;
      F2: begin
        state_next   = IDLE;
        if_resp_next = !io_flush;
      end
      D0: state_next = D1;
      D1: begin
        state_next    = IDLE;
        lsu_resp_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, starvation counter and response pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 4'd0;
      if_resp_reg    <= 1'b0;
      lsu_resp_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_resp_reg  <= if_resp_next;
      lsu_resp_reg <= lsu_resp_next;
      if (if_grant)
        starve_cnt_reg <= 4'd0;
      else if (lsu_grant && io_if_req_valid && !starve_hit)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  // Memory-side request registers: loaded on grant, stepped between fetch
  // beats, otherwise holding so idle cycles keep the last driven values.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_func3_reg <= 3'd0;
      store_reg     <= 1'b0;
    end else if (if_grant) begin
      mem_addr_reg <= io_if_req_addr & WORD_MASK;
    end else if (lsu_grant) begin
      mem_addr_reg  <= io_lsu_req_addr;
      mem_wdata_reg <= io_lsu_req_writeData;
      mem_func3_reg <= io_lsu_req_func3;
      store_reg     <= io_lsu_req_writeEn;
    end else if (state_reg == F0 && !io_flush) begin
      mem_addr_reg <= mem_addr_reg + WORD_STEP;
    end
  end

  // Read-data capture one cycle after each read beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_0_reg   <= '0;
      inst_1_reg   <= '0;
      lsu_data_reg <= '0;
    end else begin
      if (state_reg == F1) inst_0_reg <= io_mem_rdata;
      if (state_reg == F2) inst_1_reg <= io_mem_rdata;
      if (state_reg == D1 && !store_reg) lsu_data_reg <= io_mem_rdata;
    end
  end

  // Output drive; a scheduled fetch response is dropped if flush lands on it.
  always_comb begin
    io_if_req_ready   = if_grant;
    io_lsu_req_ready  = lsu_grant;
    io_if_resp_valid  = if_resp_reg && !io_flush;
    io_if_resp_inst_0 = inst_0_reg;
    io_if_resp_inst_1 = inst_1_reg;
    io_lsu_resp_valid = lsu_resp_reg;
    io_lsu_resp_data  = lsu_data_reg;
    io_mem_en         = (state_reg == F0) || (state_reg == F1) || (state_reg == D0);
    io_mem_addr       = mem_addr_reg;
    io_mem_writeEn    = (state_reg == D0) && store_reg;
    io_mem_writeData  = mem_wdata_reg;
    io_mem_func3      = mem_func3_reg;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_fetch_grants_reg, perf_lsu_grants_reg, perf_fetch_stall_reg;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_grants_reg <= 32'd0;
      perf_lsu_grants_reg   <= 32'd0;
      perf_fetch_stall_reg  <= 32'd0;
    end else begin
      if (if_grant)  perf_fetch_grants_reg <= perf_fetch_grants_reg + 32'd1;
      if (lsu_grant) perf_lsu_grants_reg   <= perf_lsu_grants_reg + 32'd1;
      if (io_if_req_valid && !if_grant)
        perf_fetch_stall_reg <= perf_fetch_stall_reg + 32'd1;
    end
  end

  assign io_perf_fetch_grants = perf_fetch_grants_reg;
  assign io_perf_lsu_grants   = perf_lsu_grants_reg;
  assign io_perf_fetch_stall  = perf_fetch_stall_reg;
`endif

endmodule
